// File: rtl/uart_echo_pkg.sv
// -----------------------------------------------------------------------------
// uart_echo_pkg
//  Shared definitions for the UART echo FIFO stage: TX FSM state encoding,
//  ASCII constants used by the optional CR->CRLF expansion, and the saturating
//  error-counter helper.
//  Optional feature macro used by the importing RTL: UART_ECHO_CRLF_EN.
// -----------------------------------------------------------------------------
package uart_echo_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        CRLF      = 3'd4
    } tx_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ERR_MAX  = 8'hFF;

    // Adds 0..2 events to an 8-bit counter, clamping at ERR_MAX.
    function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + {7'b0, inc};
        return sum[8] ? ERR_MAX : sum[7:0];
    endfunction

endpackage

// File: rtl/uart_echo_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//  Single-clock FIFO with first-word-fall-through read data. A pop in the same
//  cycle as a push at full frees the slot first, so the push is accepted.
//  Parameters: DEPTH (power of two), ADDR_W = log2(DEPTH), WIDTH (data bits).
//  Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_data  write request and data (ignored when full without pop)
//   pop              read request (ignored when empty)
//   pop_data         entry at the read pointer
//   count            entries stored, 0..DEPTH
//   empty, full      count == 0 / count == DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  pop_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: the storage array has no reset; only pointers and count define
    // which entries are valid, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == DEPTH[ADDR_W:0]);

endmodule

// File: rtl/uart_echo_fifo.sv
// -----------------------------------------------------------------------------
// uart_echo_fifo
//  Buffers bytes from the UART receiver and replays them one frame at a time
//  through the transmitter's start/busy handshake, so RX bursts arriving while
//  TX is busy are queued instead of lost.
//  Optional feature: define UART_ECHO_CRLF_EN to follow every echoed 0x0D with
//  a generated 0x0A (not stored in the FIFO, not counted in fifo_count).
//  Ports:
//   clk, rst     clock, asynchronous active-high reset
//   rx_valid     one-cycle strobe, rx_data valid
//   rx_data      received byte
//   rx_error     one-cycle framing-error strobe (byte discarded, error counted)
//   tx_busy      transmitter busy
//   tx_start     one-cycle transmit request
//   tx_data      byte being transmitted, held until the next load
//   ovf_clr      clears ovf_flag (a drop in the same cycle wins)
//   fifo_count   entries stored, fifo_empty / fifo_full status
//   ovf_flag     sticky: a byte was dropped because the FIFO was full
//   err_count    saturating count of rx errors and TX start timeouts
// -----------------------------------------------------------------------------
module uart_echo_fifo #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int START_TO = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_error,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              ovf_clr,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              ovf_flag,
    output logic [7:0]        err_count
);

    import uart_echo_pkg::*;

`ifdef UART_ECHO_CRLF_EN
    localparam bit CRLF_EN = 1'b1;
`else
    localparam bit CRLF_EN = 1'b0;
`endif

    localparam int              TO_W    = $clog2(START_TO + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TO - 1);

    tx_state_t       state;
    tx_state_t       state_nx;
    logic [TO_W-1:0] to_cnt;
    logic            timeout;
    logic            push_req;
    logic            pop;
    logic            drop;
    logic [7:0]      fifo_rd_data;

    assign push_req = rx_valid && !rx_error;
    assign pop      = (state == LOAD);
    // A push at full is only lost when no pop frees a slot in the same cycle.
    assign drop     = push_req && fifo_full && !pop;
    // Transmitter never acknowledged within START_TO cycles: give up on the byte.
    assign timeout  = (state == WAIT_BUSY) && !tx_busy && (to_cnt == TO_LAST);

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (rx_data),
        .pop       (pop),
        .pop_data  (fifo_rd_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: state_nx gets its default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_nx = state;
        unique case (state)
            // Waiting for !tx_busy keeps tx_start from firing into a busy core.
            IDLE:      if (!fifo_empty && !tx_busy) state_nx = LOAD;
            LOAD:      state_nx = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nx = WAIT_DONE;
                end else if (timeout) begin
                    state_nx = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nx = (CRLF_EN && tx_data == ASCII_CR) ? CRLF : IDLE;
                end
            end
            CRLF:      state_nx = WAIT_BUSY;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            to_cnt    <= '0;
            ovf_flag  <= 1'b0;
            err_count <= 8'h00;
        end else begin
            tx_start <= (state == LOAD) || (state == CRLF);

            if (state == LOAD) begin
                tx_data <= fifo_rd_data;
            end else if (state == CRLF) begin
                tx_data <= ASCII_LF;
            end

            if (state == WAIT_BUSY) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end

            if (drop) begin
                ovf_flag <= 1'b1;
            end else if (ovf_clr) begin
                ovf_flag <= 1'b0;
            end

            err_count <= sat_add(err_count, {1'b0, rx_error} + {1'b0, timeout});
        end
    end

endmodule

// File: tb/tb_uart_echo_fifo.sv
module tb_uart_echo_fifo;

`ifdef UART_ECHO_CRLF_EN
    localparam bit CRLF_EN = 1'b1;
`else
    localparam bit CRLF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       ovf_clr;
    logic [4:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_full;
    logic       ovf_flag;
    logic [7:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Transmitter model: acknowledges tx_start with tx_busy for frame_len cycles.
    int   frame_len = 10;
    bit   respond   = 1'b1;
    bit   hold_busy = 1'b0;
    logic core_busy;
    int   busy_left;
    int   n_start_busy = 0;

    logic [7:0] tx_q[$];
    logic [7:0] exp_tx[$];
    int         chk_idx = 0;
    int         exp_err = 0;

    uart_echo_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_error   (rx_error),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .ovf_clr    (ovf_clr),
        .fifo_count (fifo_count),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .ovf_flag   (ovf_flag),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    assign tx_busy = core_busy | hold_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_busy <= 1'b0;
            busy_left <= 0;
        end else if (tx_start && respond && !core_busy) begin
            core_busy <= 1'b1;
            busy_left <= frame_len;
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else if (core_busy) begin
            busy_left <= 0;
            core_busy <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!rst && tx_start) begin
            tx_q.push_back(tx_data);
            if (tx_busy) n_start_busy <= n_start_busy + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; drives one receive strobe and returns at the next negedge.
    task automatic rx_byte(input logic [7:0] b, input logic e);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_error = e;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_tx.push_back(b);
        if (CRLF_EN && b == 8'h0D) exp_tx.push_back(8'h0A);
    endtask

    task automatic wait_tx(input int n, input string tag);
        int cyc;
        cyc = 0;
        while ((tx_q.size() < n || tx_busy) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        check({"wait_", tag}, 32'(cyc < 3000), 32'd1);
    endtask

    task automatic check_tx(input string tag);
        check({tag, "_len"}, tx_q.size(), exp_tx.size());
        for (int i = chk_idx; i < exp_tx.size() && i < tx_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), tx_q[i], exp_tx[i]);
        end
        chk_idx = exp_tx.size();
    endtask

    initial begin
        int cyc;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_error = 1'b0;
        ovf_clr  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_count", fifo_count, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full",  fifo_full, 0);
        check("rst_start", tx_start, 0);
        check("rst_data",  tx_data, 8'h00);
        check("rst_ovf",   ovf_flag, 0);
        check("rst_err",   err_count, 0);
        rst = 1'b0;

        // 1. Single byte latency: push edge N, tx_start high after edge N+2
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h41;
        @(negedge clk);
        rx_valid = 1'b0;
        check("t1_count_after_push", fifo_count, 1);
        check("t1_start_n1", tx_start, 0);
        @(negedge clk);
        check("t1_start_n2", tx_start, 0);
        @(negedge clk);
        check("t1_start_n3", tx_start, 1);
        check("t1_data", tx_data, 8'h41);
        check("t1_count_after_pop", fifo_count, 0);
        @(negedge clk);
        check("t1_start_pulse", tx_start, 0);
        expect_byte(8'h41);
        wait_tx(exp_tx.size(), "t1");
        check_tx("t1");

        // 2. Burst of 20 while TX held busy; last drop coincides with ovf_clr
        hold_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ovf_clr = (i == 19);
            rx_byte(8'(i), 1'b0);
        end
        ovf_clr = 1'b0;
        check("t2_count_full", fifo_count, 16);
        check("t2_full", fifo_full, 1);
        check("t2_ovf_set_wins", ovf_flag, 1);
        check("t2_no_tx", tx_q.size(), chk_idx);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("t2_ovf_clr", ovf_flag, 0);
        // Release TX; push lands in the LOAD cycle while full: accepted, no overflow
        hold_busy = 1'b0;
        @(negedge clk);
        rx_byte(8'hA5, 1'b0);
        check("t2_pushpop_count", fifo_count, 16);
        check("t2_pushpop_full", fifo_full, 1);
        check("t2_pushpop_ovf", ovf_flag, 0);
        for (int i = 0; i < 16; i++) expect_byte(8'(i));
        expect_byte(8'hA5);
        wait_tx(exp_tx.size(), "t2");
        check_tx("t2");
        check("t2_empty", fifo_empty, 1);

        // 3. Framing error: not stored, counted, nothing sent
        rx_byte(8'h55, 1'b1);
        exp_err++;
        repeat (6) @(negedge clk);
        check("t3_count", fifo_count, 0);
        check("t3_err", err_count, exp_err);
        check("t3_no_tx", tx_q.size(), chk_idx);

        // 4. Start timeout: transmitter ignores tx_start
        respond = 1'b0;
        rx_byte(8'h3C, 1'b0);
        cyc = 0;
        while (tx_start !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_start_seen", 32'(cyc < 20), 32'd1);
        repeat (7) @(negedge clk);
        check("t4_err_before_to", err_count, exp_err);
        @(negedge clk);
        exp_err++;
        check("t4_err_at_to", err_count, exp_err);
        respond = 1'b1;
        rx_byte(8'h3D, 1'b0);
        expect_byte(8'h3C);
        expect_byte(8'h3D);
        wait_tx(exp_tx.size(), "t4");
        check_tx("t4");

        // 5. Reset while in WAIT_DONE with 3 bytes queued
        frame_len = 30;
        for (int i = 0; i < 4; i++) rx_byte(8'h61 + 8'(i), 1'b0);
        cyc = 0;
        while (tx_busy !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_busy_seen", 32'(cyc < 50), 32'd1);
        repeat (3) @(negedge clk);
        check("t5_queued", fifo_count, 3);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_count", fifo_count, 0);
        check("t5_rst_empty", fifo_empty, 1);
        check("t5_rst_full",  fifo_full, 0);
        check("t5_rst_start", tx_start, 0);
        check("t5_rst_data",  tx_data, 8'h00);
        check("t5_rst_ovf",   ovf_flag, 0);
        check("t5_rst_err",   err_count, 0);
        exp_err = 0;
        @(negedge clk);
        rst = 1'b0;
        frame_len = 10;
        repeat (40) @(negedge clk);
        expect_byte(8'h61);
        check_tx("t5");

        // 6. Carriage return: one frame, or CR then generated LF
        rx_byte(8'h0D, 1'b0);
        expect_byte(8'h0D);
        wait_tx(exp_tx.size(), "t6");
        check_tx("t6");
        check("t6_count", fifo_count, 0);

        // Randomized bursts against the queue model
        for (int burst = 0; burst < 6; burst++) begin
            int len;
            len = $urandom_range(8, 1);
            for (int k = 0; k < len; k++) begin
                logic [7:0] b;
                bit         e;
                b = 8'($urandom);
                e = ($urandom_range(7, 0) == 0);
                rx_byte(b, e);
                if (e) exp_err++;
                else   expect_byte(b);
                repeat ($urandom_range(2, 0)) @(negedge clk);
            end
            wait_tx(exp_tx.size(), $sformatf("rnd%0d", burst));
            check_tx($sformatf("rnd%0d", burst));
            check($sformatf("rnd%0d_err", burst), err_count, exp_err);
        end

        check("start_while_busy", n_start_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
